// File: rtl/commit_unit.sv
// Commit stage: retires decoded instructions into the PC and register file,
// issuing a single outstanding data-RAM request for memory-sourced results.
//
// state  | meaning
// IDLE   | ready to accept a decoded instruction
// MEM    | data-RAM request outstanding, waiting for mem_ack
// HALTED | halt instruction accepted; frozen until rst
module commit_unit #(
    parameter logic [15:0] RESET_PC = 16'h0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic        should_halt,
    input  logic [15:0] res,
    input  logic        res_from_ram,
    input  logic [2:0]  res_target,
    input  logic [15:0] ram_addr,
    input  logic        ram_op,
    input  logic [15:0] ram_write,
    input  logic [2:0]  ram_mode,
    output logic        mem_req,
    input  logic        mem_ack,
    output logic [15:0] mem_addr,
    output logic        mem_we,
    output logic [15:0] mem_wdata,
    output logic [2:0]  mem_mode,
    input  logic [15:0] mem_rdata,
    output logic [15:0] pc,
    output logic [95:0] reg_file,
    output logic        halted,
    output logic        retire,
    output logic [15:0] retire_count
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        MEM    = 2'd1,
        HALTED = 2'd2
    } state_t;

    state_t      state;
    logic        lat_op;
    logic [2:0]  lat_target;
    logic [15:0] lat_addr;
    logic [15:0] lat_wdata;
    logic [2:0]  lat_mode;

    logic        accept;
    logic        commit_en;
    logic        commit_store;
    logic [15:0] commit_val;
    logic [2:0]  commit_tgt;
    logic [15:0] next_pc;

    assign in_ready  = (state == IDLE);
    assign mem_req   = (state == MEM);
    assign mem_we    = (state == MEM) & lat_op;
    assign halted    = (state == HALTED);
    assign mem_addr  = lat_addr;
    assign mem_wdata = lat_wdata;
    assign mem_mode  = lat_mode;
    assign accept    = in_valid & in_ready;

    always_comb begin
        commit_en    = 1'b0;
        commit_store = 1'b0;
        commit_val   = res;
        commit_tgt   = res_target;
        case (state)
            IDLE: begin
                commit_en = accept & ~should_halt & ~res_from_ram;
            end
            MEM: begin
                commit_en    = mem_ack;
                commit_store = lat_op;
                commit_val   = mem_rdata;
                commit_tgt   = lat_target;
            end
            default: begin
                commit_en = 1'b0;
            end
        endcase
    end

    // Stores never redirect the PC, whatever target they carry.
    always_comb begin
        next_pc = pc + 16'd1;
        if (!commit_store && commit_tgt == 3'd1) begin
            next_pc = commit_val;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            pc           <= RESET_PC;
            reg_file     <= '0;
            retire       <= 1'b0;
            retire_count <= '0;
            lat_op       <= 1'b0;
            lat_target   <= '0;
            lat_addr     <= '0;
            lat_wdata    <= '0;
            lat_mode     <= '0;
        end else begin
            retire <= commit_en;
            if (commit_en) begin
                pc           <= next_pc;
                retire_count <= retire_count + 16'd1;
                if (!commit_store) begin
                    for (int i = 2; i < 8; i++) begin
                        if (commit_tgt == 3'(i)) begin
                            reg_file[16*(i-2) +: 16] <= commit_val;
                        end
                    end
                end
            end
            case (state)
                IDLE: begin
                    if (accept) begin
                        if (should_halt) begin
                            state <= HALTED;
                        end else if (res_from_ram) begin
                            lat_op     <= ram_op;
                            lat_target <= res_target;
                            lat_addr   <= ram_addr;
                            lat_wdata  <= ram_write;
                            lat_mode   <= ram_mode;
                            state      <= MEM;
                        end
                    end
                end
                MEM: begin
                    if (mem_ack) begin
                        state <= IDLE;
                    end
                end
                HALTED: begin
                    state <= HALTED;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_commit_unit.sv
// Directed bench for commit_unit: commits are scoreboarded on the retire pulse,
// handshake and halt/reset behaviour are checked inline.
module tb_commit_unit;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic        should_halt;
    logic [15:0] res;
    logic        res_from_ram;
    logic [2:0]  res_target;
    logic [15:0] ram_addr;
    logic        ram_op;
    logic [15:0] ram_write;
    logic [2:0]  ram_mode;
    logic        mem_req;
    logic        mem_ack;
    logic [15:0] mem_addr;
    logic        mem_we;
    logic [15:0] mem_wdata;
    logic [2:0]  mem_mode;
    logic [15:0] mem_rdata;
    logic [15:0] pc;
    logic [95:0] reg_file;
    logic        halted;
    logic        retire;
    logic [15:0] retire_count;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [15:0] pc;
        logic [95:0] rf;
        logic [15:0] cnt;
    } exp_t;

    exp_t sb[$];

    commit_unit dut (
        .clk          (clk),
        .rst          (rst),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .should_halt  (should_halt),
        .res          (res),
        .res_from_ram (res_from_ram),
        .res_target   (res_target),
        .ram_addr     (ram_addr),
        .ram_op       (ram_op),
        .ram_write    (ram_write),
        .ram_mode     (ram_mode),
        .mem_req      (mem_req),
        .mem_ack      (mem_ack),
        .mem_addr     (mem_addr),
        .mem_we       (mem_we),
        .mem_wdata    (mem_wdata),
        .mem_mode     (mem_mode),
        .mem_rdata    (mem_rdata),
        .pc           (pc),
        .reg_file     (reg_file),
        .halted       (halted),
        .retire       (retire),
        .retire_count (retire_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [95:0] act, input logic [95:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic push_exp(input logic [15:0] p, input logic [95:0] rf, input logic [15:0] c);
        exp_t e;
        e.pc  = p;
        e.rf  = rf;
        e.cnt = c;
        sb.push_back(e);
    endtask

    // Monitor: every retire pulse must match the oldest queued expectation.
    always @(negedge clk) begin
        if (retire) begin
            if (sb.size() == 0) begin
                chk("unexpected_retire", 96'd1, 96'd0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("sb_pc", 96'(pc), 96'(e.pc));
                chk("sb_reg_file", reg_file, e.rf);
                chk("sb_retire_count", 96'(retire_count), 96'(e.cnt));
            end
        end
    end

    task automatic idle_inputs();
        in_valid     = 1'b0;
        should_halt  = 1'b0;
        res          = '0;
        res_from_ram = 1'b0;
        res_target   = '0;
        ram_addr     = '0;
        ram_op       = 1'b0;
        ram_write    = '0;
        ram_mode     = '0;
        mem_ack      = 1'b0;
        mem_rdata    = '0;
    endtask

    task automatic check_reset_state();
        chk("rst_pc", 96'(pc), 96'h0000);
        chk("rst_reg_file", reg_file, 96'h0);
        chk("rst_retire_count", 96'(retire_count), 96'h0);
        chk("rst_retire", 96'(retire), 96'h0);
        chk("rst_halted", 96'(halted), 96'h0);
        chk("rst_in_ready", 96'(in_ready), 96'h1);
        chk("rst_mem_req", 96'(mem_req), 96'h0);
        chk("rst_mem_we", 96'(mem_we), 96'h0);
        chk("rst_mem_addr", 96'(mem_addr), 96'h0);
    endtask

    task automatic alu(input logic [15:0] r, input logic [2:0] t,
                       input logic [15:0] e_pc, input logic [95:0] e_rf, input logic [15:0] e_cnt);
        @(negedge clk);
        push_exp(e_pc, e_rf, e_cnt);
        in_valid     = 1'b1;
        should_halt  = 1'b0;
        res_from_ram = 1'b0;
        res          = r;
        res_target   = t;
        @(negedge clk);
        idle_inputs();
    endtask

    task automatic mem_instr(input logic [15:0] addr, input logic op, input logic [15:0] wd,
                             input logic [2:0] t, input int wait_cycles, input logic [15:0] rd,
                             input logic [15:0] e_pc, input logic [95:0] e_rf, input logic [15:0] e_cnt);
        @(negedge clk);
        push_exp(e_pc, e_rf, e_cnt);
        in_valid     = 1'b1;
        res_from_ram = 1'b1;
        res          = 16'hDEAD;
        res_target   = t;
        ram_addr     = addr;
        ram_op       = op;
        ram_write    = wd;
        ram_mode     = 3'd2;
        @(negedge clk);
        // Different fields presented while busy must not disturb the request.
        res_from_ram = 1'b0;
        res_target   = 3'd6;
        ram_addr     = ~addr;
        ram_write    = ~wd;
        ram_op       = ~op;
        ram_mode     = 3'd5;
        for (int i = 0; i <= wait_cycles; i++) begin
            chk("mem_req_held", 96'(mem_req), 96'h1);
            chk("in_ready_in_mem", 96'(in_ready), 96'h0);
            chk("mem_addr_stable", 96'(mem_addr), 96'(addr));
            chk("mem_we", 96'(mem_we), 96'(op));
            chk("mem_wdata", 96'(mem_wdata), 96'(wd));
            chk("mem_mode", 96'(mem_mode), 96'h2);
            if (i == wait_cycles) begin
                mem_ack   = 1'b1;
                mem_rdata = rd;
                in_valid  = 1'b0;
            end
            @(negedge clk);
        end
        idle_inputs();
        chk("mem_req_after_ack", 96'(mem_req), 96'h0);
        chk("mem_we_after_ack", 96'(mem_we), 96'h0);
        chk("in_ready_after_ack", 96'(in_ready), 96'h1);
        chk("mem_addr_hold", 96'(mem_addr), 96'(addr));
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "timeout");
    end

    initial begin
        idle_inputs();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        check_reset_state();

        alu(16'h1234, 3'd3, 16'h0001, 96'h0000_0000_0000_0000_1234_0000, 16'd1);
        chk("reg3_slice", 96'(reg_file[31:16]), 96'h1234);
        mem_instr(16'h0040, 1'b0, 16'h0000, 3'd5, 3, 16'hBEEF,
                  16'h0002, 96'h0000_0000_BEEF_0000_1234_0000, 16'd2);
        mem_instr(16'h0041, 1'b1, 16'h00AA, 3'd4, 0, 16'h5A5A,
                  16'h0003, 96'h0000_0000_BEEF_0000_1234_0000, 16'd3);
        alu(16'h1111, 3'd2, 16'h0004, 96'h0000_0000_BEEF_0000_1234_1111, 16'd4);
        alu(16'hFFFF, 3'd0, 16'h0005, 96'h0000_0000_BEEF_0000_1234_1111, 16'd5);
        alu(16'h0010, 3'd1, 16'h0010, 96'h0000_0000_BEEF_0000_1234_1111, 16'd6);
        alu(16'hFFFF, 3'd1, 16'hFFFF, 96'h0000_0000_BEEF_0000_1234_1111, 16'd7);
        alu(16'h7777, 3'd7, 16'h0000, 96'h7777_0000_BEEF_0000_1234_1111, 16'd8);
        mem_instr(16'h0100, 1'b0, 16'h0000, 3'd0, 0, 16'h5555,
                  16'h0001, 96'h7777_0000_BEEF_0000_1234_1111, 16'd9);
        mem_instr(16'h0200, 1'b1, 16'h0033, 3'd1, 1, 16'h9999,
                  16'h0002, 96'h7777_0000_BEEF_0000_1234_1111, 16'd10);

        @(negedge clk);
        mem_ack   = 1'b1;
        mem_rdata = 16'h4321;
        repeat (3) @(negedge clk);
        idle_inputs();
        chk("idle_ack_pc", 96'(pc), 96'h0002);
        chk("idle_ack_count", 96'(retire_count), 96'd10);
        chk("idle_ack_mem_req", 96'(mem_req), 96'h0);

        @(negedge clk);
        in_valid    = 1'b1;
        should_halt = 1'b1;
        res         = 16'h2222;
        res_target  = 3'd2;
        @(negedge clk);
        chk("halted_set", 96'(halted), 96'h1);
        should_halt = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk("halted_in_ready", 96'(in_ready), 96'h0);
            chk("halted_hold", 96'(halted), 96'h1);
            chk("halted_retire", 96'(retire), 96'h0);
        end
        idle_inputs();
        chk("halted_pc", 96'(pc), 96'h0002);
        chk("halted_count", 96'(retire_count), 96'd10);
        chk("halted_reg_file", reg_file, 96'h7777_0000_BEEF_0000_1234_1111);

        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check_reset_state();

        @(negedge clk);
        in_valid     = 1'b1;
        res_from_ram = 1'b1;
        ram_addr     = 16'h0080;
        ram_op       = 1'b0;
        res_target   = 3'd3;
        @(negedge clk);
        chk("abandon_mem_req", 96'(mem_req), 96'h1);
        rst       = 1'b1;
        mem_ack   = 1'b1;
        mem_rdata = 16'hABCD;
        in_valid  = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        idle_inputs();
        check_reset_state();

        alu(16'h00FF, 3'd6, 16'h0001, 96'h0000_00FF_0000_0000_0000_0000, 16'd1);

        repeat (3) @(negedge clk);
        chk("sb_drained", 96'(sb.size()), 96'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
